id_ex_hazard_ctrl: RTL
======================

Name: id_ex_hazard_ctrl

Overview:
- Control block that drives the ID/EX pipeline register and the stages upstream of it.
- Watches the instruction in ID and the instruction latched in ID/EX, plus EX branch resolution and a memory-busy flag.
- Generates PC/IF-ID/ID-EX write enables, the IF/ID flush and the ID/EX bubble (zeroed controls).
- Keeps saturating performance counters for stall cycles and flush events.

Parameters:
- FLUSH_EXTRA, 1, extra cycles IF/ID flush stays asserted after a taken branch (0..7); covers instruction-memory latency.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_uses_rt  in  1  ID instruction reads rt (R-type, beq, sw)
- ex_rt  in  5  rt held in ID/EX
- ex_mem_read  in  1  MemRead held in ID/EX
- branch_taken  in  1  branch/jump resolved taken in EX this cycle
- mem_stall  in  1  data memory busy; freeze whole front end
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID loads a nop
- idex_write  out  1  ID/EX load enable
- idex_bubble  out  1  ID/EX loads all control bits = 0
- busy_flush  out  1  high while in FLUSH state
- stall_cycles  out  CNT_W  count of load-use stall cycles, saturating
- flush_events  out  CNT_W  count of accepted taken branches, saturating

Behaviour:
- Hazard term: lu = ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & ex_rt == id_rt)). Register 0 never hazards.
- FSM states: RUN, FLUSH. A 3-bit flush_left counter is used in FLUSH.
- Enable/flush outputs are combinational from state and inputs. Counters and state are registered.
- Priority (highest first): reset, mem_stall, branch_taken, FLUSH state, lu.
- mem_stall=1:
  - pc_write=ifid_write=idex_write=0; ifid_flush=idex_bubble=0.
  - State, flush_left and counters hold.
  - branch_taken is ignored; EX is frozen, so the branch re-presents next cycle.
- RUN, branch_taken=1:
  - pc_write=1, ifid_write=1, ifid_flush=1, idex_write=1, idex_bubble=1.
  - flush_events increments.
  - If FLUSH_EXTRA>0: next state FLUSH, flush_left<=FLUSH_EXTRA. Otherwise stay in RUN.
  - Overrides lu in the same cycle; the dependent instruction is squashed anyway.
- FLUSH:
  - pc_write=1, ifid_write=1, ifid_flush=1, idex_write=1, idex_bubble=1.
  - busy_flush=1; flush_left decrements each non-frozen cycle; at 1 go to RUN.
  - branch_taken in FLUSH is ignored and not counted (EX holds a bubble).
  - lu is not evaluated.
- RUN, lu=1, no branch:
  - pc_write=0, ifid_write=0, idex_write=1, idex_bubble=1, ifid_flush=0.
  - stall_cycles increments.
  - Next cycle a bubble sits in ID/EX (ex_mem_read=0), so lu clears naturally. The stall is exactly 1 cycle per load-use.
- RUN, idle (no branch, no lu): pc_write=ifid_write=idex_write=1, ifid_flush=idex_bubble=0.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Reset, sampled on clk, overrides everything, including mid-FLUSH:
  - state=RUN, flush_left=0, both counters=0.
  - During the reset cycle: pc_write=ifid_write=idex_write=1, ifid_flush=idex_bubble=1.
- busy_flush reset value: 0.

Test Plan:
- Load-use: ex_mem_read=1, ex_rt=5, id_rs=5 for one cycle -> pc_write=0, ifid_write=0, idex_bubble=1, stall_cycles 0->1. Next cycle with ex_mem_read=0 -> all writes 1, bubble 0.
- Zero register and rt masking:
  - ex_mem_read=1, ex_rt=0, id_rs=0 -> no stall.
  - ex_rt=7, id_rt=7, id_uses_rt=0 -> no stall.
  - Same with id_uses_rt=1 -> stall.
- Taken branch, FLUSH_EXTRA=1: branch_taken pulse -> ifid_flush=1, idex_bubble=1 that cycle and the next; busy_flush=1 for 1 cycle; flush_events=1. A second branch_taken during FLUSH is not counted.
- mem_stall precedence: lu condition and branch_taken both high with mem_stall=1 for 3 cycles -> all write enables 0, counters unchanged. mem_stall drops with branch_taken still high -> flush taken, flush_events+1.
- Saturation: with CNT_W=4, hold lu for 20 non-consecutive stall events -> stall_cycles stops at 15.
- Reset mid-FLUSH (FLUSH_EXTRA=3, reset at flush_left=2) -> next cycle state RUN, busy_flush=0, counters 0.

Source files
------------

// File: rtl/id_ex_hazard_ctrl.sv
// id_ex_hazard_ctrl: ID/EX hazard control with load-use stall, branch flush and saturating perf counters
module id_ex_hazard_ctrl #(
    parameter int FLUSH_EXTRA = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic [4:0]       ex_rt,
    input  logic             ex_mem_read,
    input  logic             branch_taken,
    input  logic             mem_stall,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_bubble,
    output logic             busy_flush,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);
    typedef enum logic {RUN, FLUSH} state_t;
    state_t state;
    logic [2:0] flush_left;
    logic lu, in_flush, stall_ev;
    assign lu = ex_mem_read && ex_rt != 5'd0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
    assign in_flush = state == FLUSH;
    assign stall_ev = !mem_stall && !in_flush && !branch_taken && lu;
    // a frozen front end (mem_stall) drops every enable and flush; reset forces a clean bubble
    assign pc_write = reset || !(mem_stall || stall_ev);
    assign ifid_write = pc_write;
    assign idex_write = reset || !mem_stall;
    assign ifid_flush = reset || (!mem_stall && (in_flush || branch_taken));
    assign idex_bubble = reset || (!mem_stall && (in_flush || branch_taken || lu));
    assign busy_flush = !reset && in_flush;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            flush_left <= 3'd0;
            stall_cycles <= '0;
            flush_events <= '0;
        end else if (!mem_stall) begin
            if (in_flush) begin
                flush_left <= flush_left - 3'd1;
                if (flush_left == 3'd1) state <= RUN;
            end else if (branch_taken) begin
                if (FLUSH_EXTRA > 0) begin
                    state <= FLUSH;
                    flush_left <= 3'(FLUSH_EXTRA);
                end
                if (flush_events != '1) flush_events <= flush_events + CNT_W'(1);
            end else if (lu && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
        end
    end
endmodule
